reg_readback_unit: RTL

//   Reads every entry of the CPU register bank in turn and streams the bytes
//   out over a valid/ready byte interface for debug dumps and bench checking.

---
 rtl/readback_pkg.sv | 22 ++
 rtl/reg_readback_unit_if.sv | 23 ++
 rtl/reg_readback_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/readback_pkg.sv
// Shared definitions for the register readback unit: FSM encoding and default widths.
package readback_pkg;

  localparam int unsigned DefNregs = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = S_IDLE,
    StFetch = S_FETCH,
    StHold  = S_HOLD,
    StCsum  = S_CSUM,
    StDone  = S_DONE
  } state_e;

endpackage

// File: rtl/reg_readback_unit_if.sv
// Bank read port plus valid/ready byte stream between the readback unit and its peers.
interface reg_readback_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // master: the readback unit; slave: register bank and byte consumer
    modport master (
        output rd_addr, rd_en, out_data, out_valid,
        input  rd_data, out_ready
    );

    modport slave (
        input  rd_addr, rd_en, out_data, out_valid,
        output rd_data, out_ready
    );
endinterface

// File: rtl/reg_readback_unit.sv
// Streams every register-bank entry out as bytes over valid/ready.
// Optional trailing XOR checksum byte when READBACK_CHECKSUM_EN is defined.
module reg_readback_unit
    import readback_pkg::*;
#(
    parameter int unsigned NREGS  = DefNregs,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    reg_readback_unit_if.master bus,
    output logic                busy,
    output logic                done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NREGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hs;

`ifdef READBACK_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        hs         = out_valid_q && bus.out_ready;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end
            end
            StFetch: begin
                state_d    = StHold;
                out_data_d = bus.rd_data;
            end
            StHold: begin
                if (hs) begin
                    if (idx_q == LastIdx) begin
`ifdef READBACK_CHECKSUM_EN
                        state_d    = StCsum;
                        // csum_q excludes the byte being accepted right now
                        out_data_d = csum_q ^ out_data_q;
`else
                        state_d    = StDone;
`endif
                    end else begin
                        state_d = StFetch;
                        idx_d   = idx_q + ADDR_W'(1);
                    end
                end
            end
`ifdef READBACK_CHECKSUM_EN
            StCsum: begin
                if (hs) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase

        // abort overrides start and any handshake in flight
        if (abort) begin
            state_d = StIdle;
            idx_d   = '0;
        end

        rd_addr_d   = idx_d;
        rd_en_d     = (state_d == StFetch);
        out_valid_d = (state_d == StHold) || (state_d == StCsum);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef READBACK_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (state_q == StIdle && state_d == StFetch) begin
            csum_d = '0;
        end else if (state_q == StHold && hs && !abort) begin
            csum_d = csum_q ^ out_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
